// File: rtl/mult_seq_pkg.sv
// Shared encodings for the MULTU sequencer: ALU opcode driven while busy and the FSM state codes.
package mult_seq_pkg;

  localparam int MULT_WIDTH = 32;

  localparam logic [1:0] ALUOP_ADDU = 2'b01;

  localparam logic [1:0] MULT_IDLE = 2'b00;
  localparam logic [1:0] MULT_RUN  = 2'b01;
  localparam logic [1:0] MULT_DONE = 2'b10;

  // The shared ALU has no carry out; an unsigned add wrapped iff the sum is below an addend.
  function automatic logic add_carry(input logic [MULT_WIDTH-1:0] sum,
                                     input logic [MULT_WIDTH-1:0] addend);
    return sum < addend;
  endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Request/result and shared-ALU signals between control, datapath ALU and the MULTU sequencer.
interface mult_seq_if;
  import mult_seq_pkg::*;

  logic                  start;
  logic [MULT_WIDTH-1:0] op_a;
  logic [MULT_WIDTH-1:0] op_b;
  logic                  busy;
  logic                  done;
  logic [MULT_WIDTH-1:0] hi;
  logic [MULT_WIDTH-1:0] lo;
  logic [MULT_WIDTH-1:0] alu_num_1;
  logic [MULT_WIDTH-1:0] alu_num_2;
  logic [1:0]            alu_op;
  logic [MULT_WIDTH-1:0] alu_result;

  modport slave (
    input  start, op_a, op_b, alu_result,
    output busy, done, hi, lo, alu_num_1, alu_num_2, alu_op
  );

  modport master (
    output start, op_a, op_b, alu_result,
    input  busy, done, hi, lo, alu_num_1, alu_num_2, alu_op
  );

endinterface

// File: rtl/mult_seq.sv
// Radix-2 shift-and-add MULTU sequencer; borrows the datapath ALU (ADDU) for one partial product per cycle.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int ITERS = MULT_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  mult_seq_if.slave  bus
);

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] sum;
  logic             carry;

  // ALU operands are driven in every state; the datapath mux only listens while busy.
  assign bus.alu_op    = ALUOP_ADDU;
  assign bus.alu_num_1 = hi_q;
  assign bus.alu_num_2 = lo_q[0] ? mcand : '0;

  assign sum   = bus.alu_result;
  assign carry = add_carry(sum, hi_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MULT_IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      mcand <= '0;
    end else begin
      case (state)
        MULT_IDLE: begin
          if (bus.start) begin
            hi_q  <= '0;
            lo_q  <= bus.op_b;
            mcand <= bus.op_a;
            cnt   <= '0;
            state <= MULT_RUN;
          end
        end
        MULT_RUN: begin
          // Product shifts right through {hi,lo}; consumed multiplier bits fall off lo[0].
          hi_q <= {carry, sum[WIDTH-1:1]};
          lo_q <= {sum[0], lo_q[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) state <= MULT_DONE;
        end
        MULT_DONE: state <= MULT_IDLE;
        default:   state <= MULT_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == MULT_RUN);
  assign bus.done = (state == MULT_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: behavioural ADDU ALU in the loop, immediate-assertion checks.
module tb_mult_seq;
  import mult_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  logic mon_en   = 1'b0;

  mult_seq_if bus ();

  mult_seq #(.WIDTH(32), .ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Datapath ALU model: ADDU only; any other opcode yields a poison value.
  assign bus.alu_result = (bus.alu_op == ALUOP_ADDU) ? (bus.alu_num_1 + bus.alu_num_2)
                                                     : 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-cycle invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.done) done_cnt++;
      chk("alu_op", 64'(bus.alu_op), 64'(ALUOP_ADDU));
      chk("busy_done_excl", 64'(bus.busy & bus.done), 64'd0);
      if (bus.busy && !bus.lo[0]) chk("num2_zero", 64'(bus.alu_num_2), 64'd0);
    end
  end

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Returns cycles counted from the accept edge E0 until done is seen (0 on timeout).
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
      n = 0;
    end
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] prod);
    int n;
    pulse_start(a, b);
    wait_done(tag, n);
    chk({tag, "_lat"}, 64'(n), 64'd32);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(prod[63:32]));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(prod[31:0]));
    @(negedge clk);
    chk({tag, "_idle"}, {62'd0, bus.busy, bus.done}, 64'd0);
  endtask

  initial begin
    int n;
    int d0;
    rst = 1'b1; bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi",   64'(bus.hi),   64'd0);
    chk("rst_lo",   64'(bus.lo),   64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    run_mul("m3x5",  32'd3,          32'd5,          64'h0000_0000_0000_000F);
    run_mul("mffff", 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001);
    run_mul("m8x2",  32'h8000_0000,  32'h0000_0002,  64'h0000_0001_0000_0000);
    run_mul("m0",    32'h0000_0000,  32'h1234_5678,  64'h0);

    // Start re-pulsed mid-run and during DONE with new operands must be ignored.
    d0 = done_cnt;
    pulse_start(32'd7, 32'd9);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'h1111_1111;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ign", n);
    chk("ign_lat", 64'(n), 64'd27);
    chk("ign_lo", 64'(bus.lo), 64'd63);
    bus.start = 1'b1; bus.op_a = 32'd2; bus.op_b = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ign_busy", 64'(bus.busy), 64'd0);
    chk("ign_hi", 64'(bus.hi), 64'd0);
    chk("ign_lo_hold", 64'(bus.lo), 64'd63);
    chk("ign_single_done", 64'(done_cnt - d0), 64'd1);

    // Reset mid-run aborts without a done pulse; a fresh request then completes.
    d0 = done_cnt;
    pulse_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rrun_busy", 64'(bus.busy), 64'd0);
    chk("rrun_done", 64'(bus.done), 64'd0);
    chk("rrun_hi",   64'(bus.hi),   64'd0);
    chk("rrun_lo",   64'(bus.lo),   64'd0);
    repeat (30) @(negedge clk);
    chk("rrun_no_done", 64'(done_cnt - d0), 64'd0);
    run_mul("m6x7", 32'd6, 32'd7, 64'd42);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
